show_rect_draw: RTL and testbench
=================================

Name: show_rect_draw

Overview:
Rectangle outline rasteriser for the overlay bitmap; the stage directly downstream of the overlay sequencer.
- On a start pulse, latches one rectangle (two corners plus a 3-bit colour) and a row window.
- Emits one overlay-RAM write per cycle, walking the 1-pixel outline: top, bottom, left, right edges.
- Rows outside the window are suppressed, so each frame half of the RAM is written only in its own region.
- Worst case is 4*2^L_W cycles, well inside the 2048-cycle rect_draw slot.

Parameters:
L_W, 8, coordinate width; overlay bitmap is 2^L_W x 2^L_W.

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset; asynchronous, active-low
i_start  in  1  one-cycle pulse: latch inputs and begin drawing
i_x1  in  L_W  corner 1 x
i_y1  in  L_W  corner 1 y
i_x2  in  L_W  corner 2 x
i_y2  in  L_W  corner 2 y
i_color  in  3  pixel value to write
i_ys  in  L_W  first writable row (inclusive)
i_ye  in  L_W  last writable row (inclusive)
o_wr_en  out  1  RAM write strobe
o_wr_addr  out  2*L_W  write address {y, x}
o_wr_data  out  3  write data (latched colour)
o_busy  out  1  high while the FSM is not IDLE
o_done  out  1  one-cycle pulse after the final step

Behaviour:
- Single clock domain. Reset is asynchronous, active-low, on sys_rst_n. Reset forces FSM to IDLE and all outputs to 0, including mid-draw; no partial completion and no o_done.
- IDLE with i_start=1 latches the following:
  - xl=min(x1,x2), xr=max(x1,x2), yt=min(y1,y2), yb=max(y1,y2);
  - colour, ys, ye.
- i_start while busy is ignored; latched values are unchanged.
- Empty rectangle: x1=y1=x2=y2=0 is the reset/invalid value of the sequencer. Go IDLE -> DONE; no writes.
- State sequence:
  - TOP: y=yt, x=xl..xr.
  - BOTTOM: only if yb!=yt; y=yb, x=xl..xr.
  - LEFT: only if yb-yt>=2; x=xl, y=yt+1..yb-1.
  - RIGHT: only if yb-yt>=2 and xr!=xl; x=xr, y=yt+1..yb-1.
  - DONE: o_done=1 for one cycle, then IDLE.
- Skipped states take zero cycles; the transition goes straight to the next eligible state.
- Stepping: one pixel per cycle. Each edge is inclusive at its end; the state changes in the same cycle as the end pixel; no idle cycles between edges.
- Pixel count: w=xr-xl+1, h=yb-yt+1.
  - h==1: w pixels.
  - h>=2, w>=2: 2w+2(h-2).
  - h>=2, w==1: h.
  - No pixel is written twice.
- Timing: the first step is the cycle after i_start. Outputs are registered, so the write for step k is visible in cycle k. o_done is asserted in the cycle after the last write.
- Clipping: o_wr_en=1 only when ys<=y<=ye (unsigned). Clipped steps still consume their cycle, so draw duration is independent of the window. If ys>ye, nothing is written.
- When o_wr_en=0, o_wr_addr and o_wr_data hold their last values.
- Counters are L_W wide; coordinate 2^L_W-1 is a legal endpoint. Counters compare for equality and never wrap past an endpoint.
- o_busy is 1 from the cycle after i_start through the DONE cycle.

Test Plan:
- Normal rectangle: x1=10,y1=20,x2=13,y2=22, ys=0, ye=127, colour=3'b100. Expect 10 writes in cycles 1..10, in this order:
  - {20,10..13}, then {22,10..13};
  - {21,10}, then {21,13};
  - wr_data=4; o_done in cycle 11.
- Swapped corners: x1=13,y1=22,x2=10,y2=20 -> identical write sequence to the normal case.
- Clipping: rectangle x 0..3, y 120..130, ys=128, ye=191. The FSM steps 4+4+9+9=26 cycles. o_wr_en fires only for:
  - rows 128 and 129: x=0 and x=3;
  - row 130: x=0..3;
  - 8 writes total; o_done at cycle 27.
- Degenerate cases:
  - all coordinates 0 -> no writes, o_done at cycle 1;
  - x=5..5, y=0..3 -> 4 writes in column 5;
  - x=0..255, y=255 -> 256 writes, last address 16'hFFFF.
- Busy and reset:
  - a second i_start at cycle 3 is ignored; the original sequence is unchanged;
  - asserting sys_rst_n=0 at cycle 5 immediately drops o_wr_en and o_busy to 0;
  - after release the block is IDLE, and a new i_start draws normally.

Source files
------------

// File: rtl/show_rect_draw.sv
// Rectangle outline rasteriser: walks top, bottom, left, right edges
// one pixel per cycle and emits overlay-RAM writes inside a row window.
module show_rect_draw #(
  parameter int L_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             i_start,
  input  logic [L_W-1:0]   i_x1,
  input  logic [L_W-1:0]   i_y1,
  input  logic [L_W-1:0]   i_x2,
  input  logic [L_W-1:0]   i_y2,
  input  logic [2:0]       i_color,
  input  logic [L_W-1:0]   i_ys,
  input  logic [L_W-1:0]   i_ye,
  output logic             o_wr_en,
  output logic [2*L_W-1:0] o_wr_addr,
  output logic [2:0]       o_wr_data,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {
    IDLE, TOP, BOTTOM, LEFT, RIGHT, DONE
  } state_t;

  localparam logic [L_W-1:0] ONE = L_W'(1);
  localparam logic [L_W-1:0] TWO = L_W'(2);

  state_t state, nstate;

  logic [L_W-1:0] xl, xr, yt, yb;
  logic [L_W-1:0] ys, ye;
  logic [2:0]     color;
  logic [L_W-1:0] x, y;
  logic [L_W-1:0] nx, ny;
  logic           step;

  logic [L_W-1:0] in_xl, in_xr;
  logic [L_W-1:0] in_yt, in_yb;
  logic           in_empty;

  logic [L_W-1:0] win_ys, win_ye;
  logic [2:0]     win_color;
  logic           in_win, wr_d;

  logic has_bot, has_side, has_right;

  assign in_xl = (i_x1 < i_x2) ? i_x1 : i_x2;
  assign in_xr = (i_x1 < i_x2) ? i_x2 : i_x1;
  assign in_yt = (i_y1 < i_y2) ? i_y1 : i_y2;
  assign in_yb = (i_y1 < i_y2) ? i_y2 : i_y1;

  assign in_empty = (i_x1 == '0) && (i_y1 == '0)
                 && (i_x2 == '0) && (i_y2 == '0);

  assign has_bot   = (yb != yt);
  assign has_side  = ((yb - yt) >= TWO);
  assign has_right = has_side && (xr != xl);

  // The first pixel is issued from IDLE, before the window is latched.
  assign win_ys    = (state == IDLE) ? i_ys : ys;
  assign win_ye    = (state == IDLE) ? i_ye : ye;
  assign win_color = (state == IDLE) ? i_color : color;

  always_comb begin
    nstate = state;
    nx     = x;
    ny     = y;
    step   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          if (in_empty) begin
            nstate = DONE;
          end else begin
            nstate = TOP;
            nx     = in_xl;
            ny     = in_yt;
            step   = 1'b1;
          end
        end
      end
      TOP: begin
        if (x != xr) begin
          nx   = x + ONE;
          step = 1'b1;
        end else if (has_bot) begin
          nstate = BOTTOM;
          nx     = xl;
          ny     = yb;
          step   = 1'b1;
        end else begin
          nstate = DONE;
        end
      end
      BOTTOM: begin
        if (x != xr) begin
          nx   = x + ONE;
          step = 1'b1;
        end else if (has_side) begin
          nstate = LEFT;
          nx     = xl;
          ny     = yt + ONE;
          step   = 1'b1;
        end else begin
          nstate = DONE;
        end
      end
      LEFT: begin
        if (y != yb - ONE) begin
          ny   = y + ONE;
          step = 1'b1;
        end else if (has_right) begin
          nstate = RIGHT;
          nx     = xr;
          ny     = yt + ONE;
          step   = 1'b1;
        end else begin
          nstate = DONE;
        end
      end
      RIGHT: begin
        if (y != yb - ONE) begin
          ny   = y + ONE;
          step = 1'b1;
        end else begin
          nstate = DONE;
        end
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign in_win = (ny >= win_ys) && (ny <= win_ye);
  assign wr_d   = step && in_win;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      xl        <= '0;
      xr        <= '0;
      yt        <= '0;
      yb        <= '0;
      ys        <= '0;
      ye        <= '0;
      color     <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state   <= nstate;
      x       <= nx;
      y       <= ny;
      o_wr_en <= wr_d;
      o_busy  <= (nstate != IDLE);
      o_done  <= (nstate == DONE);
      if (wr_d) begin
        o_wr_addr <= {ny, nx};
        o_wr_data <= win_color;
      end
      if (state == IDLE && i_start) begin
        xl    <= in_xl;
        xr    <= in_xr;
        yt    <= in_yt;
        yb    <= in_yb;
        ys    <= i_ys;
        ye    <= i_ye;
        color <= i_color;
      end
    end
  end

endmodule

// File: tb/tb_show_rect_draw.sv
// Directed bench for show_rect_draw: exact write order, cycle timing,
// clipping, degenerate shapes, busy-ignore and mid-draw reset.
module tb_show_rect_draw;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_x1 = '0, i_y1 = '0;
  logic [7:0]  i_x2 = '0, i_y2 = '0;
  logic [2:0]  i_color = '0;
  logic [7:0]  i_ys = '0, i_ye = '0;
  logic        o_wr_en;
  logic [15:0] o_wr_addr;
  logic [2:0]  o_wr_data;
  logic        o_busy;
  logic        o_done;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] wq[$];
  int          cq[$];
  logic [15:0] eq[$];
  int          ec[$];
  int          done_cyc;
  int          data_bad;
  int          busy_bad;
  logic [2:0]  exp_color;

  show_rect_draw #(.L_W(8)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .i_start(i_start),
    .i_x1(i_x1),
    .i_y1(i_y1),
    .i_x2(i_x2),
    .i_y2(i_y2),
    .i_color(i_color),
    .i_ys(i_ys),
    .i_ye(i_ye),
    .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic start(input logic [7:0] x1, input logic [7:0] y1,
                       input logic [7:0] x2, input logic [7:0] y2,
                       input logic [7:0] ys, input logic [7:0] ye,
                       input logic [2:0] c);
    @(negedge sys_clk);
    i_x1 = x1; i_y1 = y1; i_x2 = x2; i_y2 = y2;
    i_ys = ys; i_ye = ye; i_color = c;
    exp_color = c;
    i_start = 1'b1;
    @(posedge sys_clk);
    #1 i_start = 1'b0;
  endtask

  // Records writes; optionally pulses a junk i_start after cycle inj.
  task automatic capture(input int maxc, input int inj);
    wq.delete(); cq.delete();
    done_cyc = -1; data_bad = 0; busy_bad = 0;
    for (int k = 1; k <= maxc && done_cyc < 0; k++) begin
      @(negedge sys_clk);
      if (o_wr_en) begin
        wq.push_back(o_wr_addr);
        cq.push_back(k);
        if (o_wr_data !== exp_color) data_bad++;
      end
      if (o_busy !== 1'b1) busy_bad++;
      if (o_done === 1'b1) done_cyc = k;
      if (k == inj) begin
        i_x1 = 8'd200; i_y1 = 8'd200; i_x2 = 8'd201; i_y2 = 8'd201;
        i_color = 3'd7; i_start = 1'b1;
      end
      if (k == inj + 1) i_start = 1'b0;
    end
  endtask

  function automatic void expw(input int yy, input int xx, input int c);
    eq.push_back({yy[7:0], xx[7:0]});
    ec.push_back(c);
  endfunction

  function automatic void exp_normal();
    int c = 1;
    eq.delete(); ec.delete();
    for (int xx = 10; xx <= 13; xx++) begin expw(20, xx, c); c++; end
    for (int xx = 10; xx <= 13; xx++) begin expw(22, xx, c); c++; end
    expw(21, 10, 9);
    expw(21, 13, 10);
  endfunction

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got en=%b addr=%h data=%h busy=%b done=%b want all 0",
               o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done);
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_normal(input logic swap);
    string nm = swap ? "swapped" : "normal";
    if (swap) start(13, 22, 10, 20, 0, 127, 3'b100);
    else      start(10, 20, 13, 22, 0, 127, 3'b100);
    capture(40, -10);
    exp_normal();
    n_checks++;
    if (wq.size() !== eq.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d want %0d", nm, wq.size(), eq.size());
    end
    for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
      n_checks++;
      if (wq[i] !== eq[i] || cq[i] !== ec[i]) begin
        n_fail++;
        $display("FAIL %s write %0d: got %h@%0d want %h@%0d",
                 nm, i, wq[i], cq[i], eq[i], ec[i]);
      end
    end
    n_checks++;
    if (done_cyc !== 11) begin
      n_fail++;
      $display("FAIL %s done cycle: got %0d want 11", nm, done_cyc);
    end
    n_checks++;
    if (data_bad !== 0 || busy_bad !== 0) begin
      n_fail++;
      $display("FAIL %s data/busy: got %0d/%0d bad want 0/0", nm, data_bad, busy_bad);
    end
    @(negedge sys_clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle after done: got busy=%b done=%b want 0 0", nm, o_busy, o_done);
    end
  endtask

  task automatic test_clip();
    start(0, 120, 3, 130, 128, 191, 3'b011);
    capture(60, -10);
    eq.delete(); ec.delete();
    for (int xx = 0; xx <= 3; xx++) expw(130, xx, 5 + xx);
    expw(128, 0, 16); expw(129, 0, 17);
    expw(128, 3, 25); expw(129, 3, 26);
    n_checks++;
    if (wq.size() !== eq.size()) begin
      n_fail++;
      $display("FAIL clip count: got %0d want %0d", wq.size(), eq.size());
    end
    for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
      n_checks++;
      if (wq[i] !== eq[i] || cq[i] !== ec[i]) begin
        n_fail++;
        $display("FAIL clip write %0d: got %h@%0d want %h@%0d",
                 i, wq[i], cq[i], eq[i], ec[i]);
      end
    end
    n_checks++;
    if (done_cyc !== 27) begin
      n_fail++;
      $display("FAIL clip done cycle: got %0d want 27", done_cyc);
    end
    n_checks++;
    if (o_wr_addr !== 16'h8103 || o_wr_data !== 3'b011) begin
      n_fail++;
      $display("FAIL clip hold: got %h/%h want 8103/3", o_wr_addr, o_wr_data);
    end
    start(10, 20, 13, 22, 50, 40, 3'b001);
    capture(40, -10);
    n_checks++;
    if (wq.size() !== 0 || done_cyc !== 11) begin
      n_fail++;
      $display("FAIL empty window: got %0d writes done@%0d want 0 done@11",
               wq.size(), done_cyc);
    end
  endtask

  task automatic test_degenerate();
    start(0, 0, 0, 0, 0, 255, 3'b010);
    capture(10, -10);
    n_checks++;
    if (wq.size() !== 0 || done_cyc !== 1 || busy_bad !== 0) begin
      n_fail++;
      $display("FAIL zero rect: got %0d writes done@%0d busybad=%0d want 0 1 0",
               wq.size(), done_cyc, busy_bad);
    end
    start(5, 3, 5, 0, 0, 255, 3'b110);
    capture(20, -10);
    eq.delete(); ec.delete();
    expw(0, 5, 1); expw(3, 5, 2); expw(1, 5, 3); expw(2, 5, 4);
    n_checks++;
    if (wq.size() !== 4 || done_cyc !== 5) begin
      n_fail++;
      $display("FAIL column: got %0d writes done@%0d want 4 done@5", wq.size(), done_cyc);
    end
    for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
      n_checks++;
      if (wq[i] !== eq[i] || cq[i] !== ec[i]) begin
        n_fail++;
        $display("FAIL column write %0d: got %h@%0d want %h@%0d",
                 i, wq[i], cq[i], eq[i], ec[i]);
      end
    end
    start(255, 255, 0, 255, 0, 255, 3'b101);
    capture(300, -10);
    n_checks++;
    if (wq.size() !== 256 || done_cyc !== 257) begin
      n_fail++;
      $display("FAIL full row: got %0d writes done@%0d want 256 done@257",
               wq.size(), done_cyc);
    end
    n_checks++;
    if (wq.size() != 256 || wq[255] !== 16'hFFFF || wq[0] !== 16'hFF00) begin
      n_fail++;
      $display("FAIL full row ends: got %0d writes, first/last %h/%h want FF00/FFFF",
               wq.size(), wq.size() > 0 ? wq[0] : 16'hx,
               wq.size() > 0 ? wq[wq.size()-1] : 16'hx);
    end
    n_checks++;
    if (data_bad !== 0) begin
      n_fail++;
      $display("FAIL full row data: got %0d bad want 0", data_bad);
    end
  endtask

  task automatic test_busy_ignore();
    start(10, 20, 13, 22, 0, 127, 3'b100);
    capture(40, 3);
    exp_normal();
    n_checks++;
    if (wq.size() !== eq.size() || done_cyc !== 11 || data_bad !== 0) begin
      n_fail++;
      $display("FAIL busy ignore: got %0d writes done@%0d databad=%0d want 10 11 0",
               wq.size(), done_cyc, data_bad);
    end
    for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
      n_checks++;
      if (wq[i] !== eq[i] || cq[i] !== ec[i]) begin
        n_fail++;
        $display("FAIL busy ignore write %0d: got %h@%0d want %h@%0d",
                 i, wq[i], cq[i], eq[i], ec[i]);
      end
    end
    @(negedge sys_clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL busy ignore restart: got busy=%b en=%b want 0 0", o_busy, o_wr_en);
    end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    start(10, 20, 13, 22, 0, 127, 3'b100);
    repeat (5) @(negedge sys_clk);
    n_checks++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 16'h160A) begin
      n_fail++;
      $display("FAIL pre-reset write: got en=%b addr=%h want 1 160a", o_wr_en, o_wr_addr);
    end
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_wr_en !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid reset: got en=%b busy=%b done=%b want 0 0 0",
               o_wr_en, o_busy, o_done);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (12) begin
      @(negedge sys_clk);
      if (o_wr_en || o_busy || o_done) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL post-reset idle: got %0d active cycles want 0", extra);
    end
    test_normal(1'b0);
  endtask

  initial begin
    exp_color = '0;
    test_reset();
    test_normal(1'b0);
    test_normal(1'b1);
    test_clip();
    test_degenerate();
    test_busy_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
